kbd_letter_sequencer: RTL and testbench
=======================================

# kbd_letter_sequencer

Converts the raw PS/2 scan-code byte stream into a queue of 4-bit letter codes for the game logic. It sits between the PS/2 byte receiver, which delivers one byte per `code_valid` strobe, and downstream consumers, which pop letters with a valid/ready handshake. It decodes make/break/extended sequences, accepts a letter only on key release, and buffers letters so that no keystroke is lost while the consumer is busy.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Must be a power of 2 and at least 2.
- `clk` input 1: the single system clock. All state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `code_valid` input 1: one-cycle strobe; `code` is valid in that cycle.
- `code` input 8: scan-code byte.
- `clear` input 1: synchronous flush of the FIFO, FSM and flags.
- `letter_valid` output 1: the FIFO is non-empty.
- `letter` output 4: head-of-FIFO letter. Only meaningful when `letter_valid` is 1.
- `letter_ready` input 1: the consumer accepts the head entry.
- `invalid_pulse` output 1: one-cycle flag meaning an unmapped key was released.
- `overflow` output 1: sticky flag meaning a letter was dropped because the FIFO was full.
- `count` output $clog2(DEPTH)+1: current number of FIFO entries.

## Operation
- **Letter map (released key → letter):**
  - 1C→0, 32→1, 21→2, 23→3, 24→4, 2B→5, 34→6, 33→7
  - 3B→8, 4B→9, 31→10, 44→11, 4D→12, 2D→13, 1B→14, 35→15
- **Ignored keys:** 12 and 59 (the two shift keys) are ignored silently.
- **FSM states:** IDLE, BREAK, EXT, EXT_BREAK. The FSM advances only on `code_valid`.
  - IDLE: F0 → BREAK; E0 → EXT; any other byte → stay in IDLE, no action. This covers make codes, AA and FA.
  - BREAK, mapped key: push the letter, go to IDLE.
  - BREAK, shift key: go to IDLE with no action.
  - BREAK, F0 or E0: go to IDLE with no action.
  - BREAK, any other byte: assert `invalid_pulse`, go to IDLE.
  - EXT: F0 → EXT_BREAK; any other byte → IDLE.
  - EXT_BREAK: any byte → IDLE. Extended keys are never pushed and never flagged.
- **FIFO:** first-word fall-through. `letter` equals the head entry combinationally from registers.
  - A pop occurs when `letter_valid && letter_ready`.
  - A push to a full FIFO without a pop in the same cycle is dropped and sets `overflow`.
  - A push and a pop in the same cycle are both accepted, including when the FIFO is full: `count` is unchanged and the order is preserved.
  - A pop while empty is impossible, because `letter_valid` is 0.
  - The read and write pointers have width $clog2(DEPTH) and wrap modulo DEPTH.
- **clear:**
  - FSM returns to IDLE; `count`, the pointers and `overflow` go to 0.
  - `clear` overrides any push, pop or `invalid_pulse` in the same cycle.
  - `overflow` clears only via `clear` or reset.

## Timing
- **Reset values:** FSM = IDLE; `count` = 0; `letter_valid` = 0; `invalid_pulse` = 0; `overflow` = 0. `letter` reads 0, because the FIFO storage is reset.
- **Letter latency:** a qualifying break byte is strobed in cycle N. `letter_valid` rises and `count` increments at the edge ending cycle N, so they are visible in cycle N+1.
- **Invalid-key latency:** for an unmapped break byte in cycle N, `invalid_pulse` is high for exactly cycle N+1.
- **Pop timing:** a pop in cycle N updates `letter` and `count` in cycle N+1.
- **Back-to-back strobes:** `code_valid` may be asserted in consecutive cycles, and each byte is processed.
- **Reset mid-sequence:** asserting `rst_n` low mid-sequence (for example after F0) discards the pending break. The FSM comes out of reset in IDLE.

## Structure
- **Package `kbd_pkg`:**
  - scan-code localparams (F0, E0, the shift keys);
  - state enum `kbd_state_t`;
  - `letter_t` (4-bit);
  - function `scan_to_letter(code, out valid)`.
- **Sub-module `letter_fifo`:** parameter DEPTH, with push/pop/clear, `count`, a full flag and FWFT output.
  - The FSM lives in the top module.
  - The FSM's push request is qualified by the full flag in the top module, which also sets `overflow`.

## Test plan
- **Basic release:** bytes 1C, F0, 1C with `letter_ready`=0 → exactly one entry; `letter`=0 and `count`=1 in the cycle after the final 1C.
- **Shift and invalid keys:** F0 12 → nothing. F0 5A → `invalid_pulse` for one cycle, `count` unchanged.
- **Extended key:** E0 75 E0 F0 75 → no push, no pulse; FSM back in IDLE. A following F0 35 pushes 15.
- **Overflow and drain:** with DEPTH=4 and `letter_ready`=0, release 0,1,2,3,4.
  - After the fifth release: `count`=4 and `overflow`=1.
  - Draining with `letter_ready`=1 yields 0,1,2,3, then `letter_valid`=0.
- **Simultaneous push/pop:** with the FIFO full and `letter_ready`=1 in the push cycle → `count` stays 4, no overflow, order preserved.
- **clear and reset:**
  - Pulse `clear` after F0 with the FIFO holding 2 entries → `count`=0, `overflow`=0; a following 1C is ignored.
  - Drop `rst_n` low asynchronously mid-stream → all outputs go to their reset values immediately.

Source files
------------

// File: rtl/kbd_letter_sequencer_pkg.sv
// Shared scan-code constants, FSM state type and the release-key letter map.
package kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BREAK     = 2'd1,
      ST_EXT       = 2'd2,
      ST_EXT_BREAK = 2'd3
   } kbd_state_t;

   typedef logic [3:0] letter_t;

   // Maps a released scan code to its letter; valid=0 for unmapped codes.
   function automatic letter_t scan_to_letter(input logic [7:0] code, output logic valid);
      letter_t l;
      l     = '0;
      valid = 1'b1;
      case (code)
         8'h1C: l = 4'd0;
         8'h32: l = 4'd1;
         8'h21: l = 4'd2;
         8'h23: l = 4'd3;
         8'h24: l = 4'd4;
         8'h2B: l = 4'd5;
         8'h34: l = 4'd6;
         8'h33: l = 4'd7;
         8'h3B: l = 4'd8;
         8'h4B: l = 4'd9;
         8'h31: l = 4'd10;
         8'h44: l = 4'd11;
         8'h4D: l = 4'd12;
         8'h2D: l = 4'd13;
         8'h1B: l = 4'd14;
         8'h35: l = 4'd15;
         default: valid = 1'b0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/kbd_letter_sequencer_if.sv
// Scan-code input strobe and letter valid/ready output bundled together.
// slave = the sequencer's view, master = the surrounding system's view.
interface kbd_letter_sequencer_if;
   import kbd_pkg::*;

   logic       code_valid;
   logic [7:0] code;
   logic       letter_valid;
   letter_t    letter;
   logic       letter_ready;

   modport master (
      output code_valid, code, letter_ready,
      input  letter_valid, letter
   );

   modport slave (
      input  code_valid, code, letter_ready,
      output letter_valid, letter
   );

endinterface

// File: rtl/kbd_letter_sequencer_fifo.sv
// First-word fall-through letter FIFO with reset storage and synchronous flush.
module letter_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_push,
   input  logic          i_pop,
   input  letter_t       i_data,
   output letter_t       o_data,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);

   letter_t           r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_do_push;
   logic              w_do_pop;
   logic [DEPTH-1:0]  w_wr_en;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   // A full FIFO still accepts a write when the head is leaving the same cycle.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign w_wr_en[gi] = w_do_push && !i_clear && (r_wr_ptr == AW'(gi));
      end
   endgenerate

   // Storage write; entries reset so the head reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (w_wr_en[i]) r_mem[i] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/kbd_letter_sequencer.sv
// Decodes PS/2 make/break/extended byte sequences and queues released letters.
module kbd_letter_sequencer
   import kbd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   kbd_letter_sequencer_if.slave     bus,
   output logic                      invalid_pulse,
   output logic                      overflow,
   output logic [$clog2(DEPTH):0]    count
);

   kbd_state_t r_state;
   kbd_state_t w_state_next;
   logic       r_invalid_pulse;
   logic       r_overflow;
   logic       w_map_valid;
   letter_t    w_map_letter;
   logic       w_push_req;
   logic       w_invalid_req;
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   letter_t    w_fifo_data;

   // Table lookup of the current byte as a released key.
   always_comb begin
      w_map_letter = scan_to_letter(bus.code, w_map_valid);
   end

   // State register; flush returns to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_state <= ST_IDLE;
      else if (clear) r_state <= ST_IDLE;
      else            r_state <= w_state_next;
   end

   // Next-state decode, advancing only on a byte strobe.
   always_comb begin
      w_state_next = r_state;
      if (bus.code_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.code == SC_BREAK)    w_state_next = ST_BREAK;
               else if (bus.code == SC_EXT) w_state_next = ST_EXT;
               else                         w_state_next = ST_IDLE;
            end
            ST_EXT:  w_state_next = (bus.code == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   // Actions on the byte following a plain break prefix; extended keys never act.
   always_comb begin
      w_push_req    = 1'b0;
      w_invalid_req = 1'b0;
      if (bus.code_valid && (r_state == ST_BREAK)) begin
         if (w_map_valid) begin
            w_push_req = 1'b1;
         end else if (bus.code != SC_LSHIFT && bus.code != SC_RSHIFT &&
                      bus.code != SC_BREAK  && bus.code != SC_EXT) begin
            w_invalid_req = 1'b1;
         end
      end
   end

   assign w_pop  = !w_empty && bus.letter_ready;
   assign w_push = w_push_req && (!w_full || w_pop);

   // One-cycle invalid flag and sticky overflow flag; flush clears both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_invalid_pulse <= 1'b0;
         r_overflow      <= 1'b0;
      end else if (clear) begin
         r_invalid_pulse <= 1'b0;
         r_overflow      <= 1'b0;
      end else begin
         r_invalid_pulse <= w_invalid_req;
         if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   letter_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (clear),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_map_letter),
      .o_data  (w_fifo_data),
      .o_count (count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.letter_valid = !w_empty;
   assign bus.letter       = w_fifo_data;
   assign invalid_pulse    = r_invalid_pulse;
   assign overflow         = r_overflow;

endmodule

// File: tb/tb_kbd_letter_sequencer.sv
// Directed bench for kbd_letter_sequencer with a queue-based reference model.
module tb_kbd_letter_sequencer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       invalid_pulse;
   logic       overflow;
   logic [2:0] count;

   kbd_letter_sequencer_if bus ();

   kbd_letter_sequencer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (clear),
      .bus           (bus),
      .invalid_pulse (invalid_pulse),
      .overflow      (overflow),
      .count         (count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: pending prefix bytes, letter queue, flags.
   int         lut [256];
   int         m_q [$];
   logic [7:0] m_seq [$];
   bit         m_ovf = 1'b0;
   bit         m_inv = 1'b0;
   bit         m_pop, m_push, m_was_full;
   int         m_let;
   logic [7:0] m_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.code_valid = 1'b1;
      bus.code       = b;
      cyc();
      bus.code_valid = 1'b0;
      $display("sent byte %02h: count=%0d valid=%0b letter=%0d inv=%0b ovf=%0b",
               b, count, bus.letter_valid, bus.letter, invalid_pulse, overflow);
   endtask

   task automatic release_key(input logic [7:0] b);
      send(8'hF0);
      send(b);
   endtask

   // Reference model: interprets the byte history as a whole sequence.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            m_seq.delete();
            m_ovf = 1'b0;
            m_inv = 1'b0;
         end else begin
            m_pop = (m_q.size() > 0) && bus.letter_ready;
            if (clear) begin
               m_q.delete();
               m_seq.delete();
               m_ovf = 1'b0;
               m_inv = 1'b0;
            end else begin
               m_push = 1'b0;
               m_inv  = 1'b0;
               if (bus.code_valid) begin
                  m_seq.push_back(bus.code);
                  if (m_seq.size() == 1) begin
                     if (m_seq[0] != 8'hF0 && m_seq[0] != 8'hE0) m_seq.delete();
                  end else if (m_seq.size() == 2) begin
                     if (m_seq[0] == 8'hF0) begin
                        m_b = m_seq[1];
                        if (lut[m_b] >= 0) begin
                           m_push = 1'b1;
                           m_let  = lut[m_b];
                        end else if (!(m_b inside {8'h12, 8'h59, 8'hF0, 8'hE0})) begin
                           m_inv = 1'b1;
                        end
                        m_seq.delete();
                     end else if (m_seq[1] != 8'hF0) begin
                        m_seq.delete();
                     end
                  end else begin
                     m_seq.delete();
                  end
               end
               m_was_full = (m_q.size() == DEPTH);
               if (m_pop) void'(m_q.pop_front());
               if (m_push) begin
                  if (m_was_full && !m_pop) m_ovf = 1'b1;
                  else                      m_q.push_back(m_let);
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("letter_valid", bus.letter_valid, m_q.size() > 0);
         chk("count", count, m_q.size());
         if (m_q.size() > 0) chk("letter", bus.letter, m_q[0]);
         chk("invalid_pulse", invalid_pulse, m_inv);
         chk("overflow", overflow, m_ovf);
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) lut[i] = -1;
      lut[8'h1C] = 0;  lut[8'h32] = 1;  lut[8'h21] = 2;  lut[8'h23] = 3;
      lut[8'h24] = 4;  lut[8'h2B] = 5;  lut[8'h34] = 6;  lut[8'h33] = 7;
      lut[8'h3B] = 8;  lut[8'h4B] = 9;  lut[8'h31] = 10; lut[8'h44] = 11;
      lut[8'h4D] = 12; lut[8'h2D] = 13; lut[8'h1B] = 14; lut[8'h35] = 15;

      bus.code_valid   = 1'b0;
      bus.code         = 8'h00;
      bus.letter_ready = 1'b0;
      repeat (2) cyc();
      chk("rst_count", count, 0);
      chk("rst_valid", bus.letter_valid, 0);
      chk("rst_letter", bus.letter, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_inv", invalid_pulse, 0);
      rst_n = 1'b1;
      cyc();

      // Basic release: make 1C is ignored, break 1C pushes letter 0.
      send(8'h1C);
      send(8'hF0);
      send(8'h1C);
      chk("basic_count", count, 1);
      chk("basic_letter", bus.letter, 0);
      chk("basic_valid", bus.letter_valid, 1);

      // Shift release is silent; unmapped release pulses for one cycle.
      release_key(8'h12);
      chk("shift_count", count, 1);
      chk("shift_inv", invalid_pulse, 0);
      release_key(8'h5A);
      chk("inv_pulse", invalid_pulse, 1);
      chk("inv_count", count, 1);
      cyc();
      chk("inv_gone", invalid_pulse, 0);

      // Extended make and break are neither pushed nor flagged.
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_count", count, 1);
      chk("ext_inv", invalid_pulse, 0);
      release_key(8'h35);
      chk("ext_after_count", count, 2);
      chk("ext_after_head", bus.letter, 0);

      bus.letter_ready = 1'b1;
      cyc();
      chk("pop1_letter", bus.letter, 15);
      chk("pop1_count", count, 1);
      cyc();
      chk("pop2_valid", bus.letter_valid, 0);
      bus.letter_ready = 1'b0;

      // Overflow: fifth release into a full FIFO is dropped.
      release_key(8'h1C); release_key(8'h32); release_key(8'h21);
      release_key(8'h23); release_key(8'h24);
      chk("ovf_count", count, 4);
      chk("ovf_flag", overflow, 1);
      bus.letter_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_letter", bus.letter, i);
         cyc();
      end
      chk("drain_empty", bus.letter_valid, 0);
      chk("ovf_sticky", overflow, 1);
      bus.letter_ready = 1'b0;
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("clr_ovf", overflow, 0);

      // Push and pop together while full.
      release_key(8'h1C); release_key(8'h32); release_key(8'h21); release_key(8'h23);
      send(8'hF0);
      bus.code_valid   = 1'b1;
      bus.code         = 8'h3B;
      bus.letter_ready = 1'b1;
      cyc();
      bus.code_valid   = 1'b0;
      bus.letter_ready = 1'b0;
      chk("pp_count", count, 4);
      chk("pp_ovf", overflow, 0);
      chk("pp_head", bus.letter, 1);
      bus.letter_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("pp_order", bus.letter, (i == 3) ? 8 : i + 1);
         cyc();
      end
      bus.letter_ready = 1'b0;

      // clear after a break prefix with two entries queued.
      release_key(8'h1C); release_key(8'h32);
      send(8'hF0);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("clr_count", count, 0);
      chk("clr_ovf2", overflow, 0);
      send(8'h1C);
      chk("clr_make_ignored", count, 0);

      // Asynchronous reset mid-sequence with the FIFO full and overflowed.
      release_key(8'h1C); release_key(8'h32); release_key(8'h21);
      release_key(8'h23); release_key(8'h24);
      send(8'hF0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_valid", bus.letter_valid, 0);
      chk("arst_letter", bus.letter, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_inv", invalid_pulse, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      send(8'h1C);
      chk("arst_break_lost", count, 0);
      release_key(8'h2D);
      chk("arst_after_count", count, 1);
      chk("arst_after_letter", bus.letter, 13);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
